// File: rtl/k2_imem_loader_if.sv
// Byte-stream link from the host/debug port into the k2 instruction memory loader.
interface k2_imem_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/k2_imem_loader.sv
// Loads the k2 instruction memory from a framed byte stream and holds the core in reset until loaded.
// Optional trailer checksum byte enabled by defining K2_LOADER_CHECKSUM_EN.
module k2_imem_loader #(
    parameter int IW = 10,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    k2_imem_loader_if.slave      s,
    input  logic [AW-1:0]        romaddress,
    output logic [IW-1:0]        inst,
    output logic                 core_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AW:0]          count
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
`ifdef K2_LOADER_CHECKSUM_EN
        CHK  = 3'd5,
`endif
        DONE = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   mem [DEPTH];
    logic [AW:0]     n;
    logic [AW-1:0]   addr;
    logic [7:0]      lo;
    logic            loaded;
    logic            xfer;
    logic            last;
    logic [AW:0]     hdr_n;
`ifdef K2_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
    logic            ck_fail;
`endif

    assign xfer = s.s_valid & s.s_ready;
    assign last = ((count + (AW+1)'(1)) == n);
    assign busy = (state != IDLE);
    assign core_rst = ~loaded | busy;
    // Read port sees the pre-edge contents even when the same word is being written.
    assign inst = mem[romaddress];

    always_comb begin
        hdr_n = s.s_data[AW:0];
        if (hdr_n == '0 || hdr_n > DEPTH_W)
            hdr_n = DEPTH_W;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        s.s_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = HDR;
            HDR: begin
                s.s_ready = 1'b1;
                if (xfer) state_next = LO;
            end
            LO: begin
                s.s_ready = 1'b1;
                if (xfer) state_next = HI;
            end
            HI: begin
                s.s_ready = 1'b1;
                if (xfer) begin
`ifdef K2_LOADER_CHECKSUM_EN
                    state_next = last ? CHK : LO;
`else
                    state_next = last ? DONE : LO;
`endif
                end
            end
`ifdef K2_LOADER_CHECKSUM_EN
            CHK: begin
                s.s_ready = 1'b1;
                if (xfer) state_next = DONE;
            end
`endif
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            n      <= '0;
            addr   <= '0;
            lo     <= '0;
            count  <= '0;
            err    <= 1'b0;
            loaded <= 1'b0;
`ifdef K2_LOADER_CHECKSUM_EN
            csum    <= '0;
            ck_fail <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    err    <= 1'b0;
                    count  <= '0;
                    loaded <= 1'b0;
`ifdef K2_LOADER_CHECKSUM_EN
                    ck_fail <= 1'b0;
`endif
                end
                HDR: if (xfer) begin
                    n    <= hdr_n;
                    addr <= '0;
`ifdef K2_LOADER_CHECKSUM_EN
                    csum <= s.s_data;
`endif
                end
                LO: if (xfer) begin
                    lo <= s.s_data;
`ifdef K2_LOADER_CHECKSUM_EN
                    csum <= csum ^ s.s_data;
`endif
                end
                HI: if (xfer) begin
                    mem[addr] <= {s.s_data[IW-9:0], lo};
                    count     <= count + (AW+1)'(1);
                    // Hold addr on the final word so it never wraps past DEPTH-1.
                    if (!last)
                        addr <= addr + AW'(1);
                    if (|s.s_data[7:IW-8])
                        err <= 1'b1;
`ifdef K2_LOADER_CHECKSUM_EN
                    csum <= csum ^ s.s_data;
`endif
                end
`ifdef K2_LOADER_CHECKSUM_EN
                CHK: if (xfer && s.s_data != csum) begin
                    err     <= 1'b1;
                    ck_fail <= 1'b1;
                end
                DONE: loaded <= ~ck_fail;
`else
                DONE: loaded <= 1'b1;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_k2_imem_loader.sv
// Randomized directed bench for k2_imem_loader against a frame-level memory model.
module tb_k2_imem_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] romaddress = '0;
    logic [9:0] inst;
    logic       core_rst, busy, done, err;
    logic [4:0] count;

    k2_imem_loader_if bus ();

    k2_imem_loader #(.IW(10), .AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s          (bus),
        .romaddress (romaddress),
        .inst       (inst),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [9:0] m_mem [16];
    bit         m_err;
    bit         m_loaded;
`ifdef K2_LOADER_CHECKSUM_EN
    logic [7:0] trailer_flip = 8'h00;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic int hdr_words(input logic [7:0] h);
        int v;
        v = int'(h[4:0]);
        return (v == 0 || v > 16) ? 16 : v;
    endfunction

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            romaddress = 4'(i);
            #1;
            check($sformatf("%s_mem%0d", tag, i), 32'(inst), 32'(m_mem[i]));
        end
        wait_edge();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        repeat ($urandom_range(0, 3)) wait_edge();
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && t < 20) begin
            wait_edge();
            t++;
        end
        if (t >= 20)
            check("ready_timeout", 32'(bus.s_ready), 32'd1);
        wait_edge();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        wait_edge();
        start = 1'b0;
        m_err    = 1'b0;
        m_loaded = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_core_rst", 32'(core_rst), 32'd1);
        check("start_err", 32'(err), 32'd0);
        check("start_count", 32'(count), 32'd0);
    endtask

    task automatic feed_session(input logic [7:0] b[$]);
        int n;
        logic [7:0] x, lo_b, hi_b;
        n = hdr_words(b[0]);
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            lo_b = b[1 + 2*i];
            hi_b = b[2 + 2*i];
            m_mem[i] = {hi_b[1:0], lo_b};
            if (hi_b[7:2] != 6'd0) m_err = 1'b1;
        end
        m_loaded = 1'b1;
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i]);
            x = x ^ b[i];
        end
`ifdef K2_LOADER_CHECKSUM_EN
        send_byte(x ^ trailer_flip);
        if (trailer_flip != 8'h00) begin
            m_err    = 1'b1;
            m_loaded = 1'b0;
        end
`endif
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        wait_edge();
        check("done_cleared", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("core_rst_after", 32'(core_rst), m_loaded ? 32'd0 : 32'd1);
        check("err_after", 32'(err), 32'(m_err));
        check("count_after", 32'(count), 32'(n));
        check_mem("sess");
    endtask

    task automatic run_session(input logic [7:0] b[$]);
        do_start();
        feed_session(b);
    endtask

    task automatic make_session(input logic [7:0] hdr, input bit clean, output logic [7:0] q[$]);
        int n;
        logic [7:0] hi_b;
        n = hdr_words(hdr);
        q = {};
        q.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            q.push_back(8'($urandom));
            hi_b = 8'($urandom);
            if (clean) hi_b = hi_b & 8'h03;
            q.push_back(hi_b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_err = 1'b0;
        m_loaded = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.s_ready), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check_mem("rst");
        reset = 1'b1;
        wait_edge();
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_core_rst", 32'(core_rst), 32'd1);

        q = '{8'h03, 8'h34, 8'h01, 8'h56, 8'h02, 8'h78, 8'h03};
        run_session(q);
        romaddress = 4'd1;
        #1;
        check("load_inst1", 32'(inst), 32'h256);

        make_session(8'h00, 1'b1, q);
        run_session(q);
        make_session(8'h02, 1'b1, q);
        run_session(q);

        q = '{8'h01, 8'hAA, 8'hFD};
        run_session(q);
        check("ferr_err", 32'(err), 32'd1);
        romaddress = 4'd0;
        #1;
        check("ferr_mem0", 32'(inst), 32'h1AA);
        wait_edge();
        do_start();
        make_session(8'h05, 1'b1, q);
        feed_session(q);

        do_start();
        make_session(8'h04, 1'b1, q);
        for (int i = 0; i < 5; i++) send_byte(q[i]);
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_loaded = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(bus.s_ready), 32'd0);
        check("mid_core_rst", 32'(core_rst), 32'd1);
        check("mid_count", 32'(count), 32'd0);
        check_mem("mid");
        reset = 1'b1;
        wait_edge();
        make_session(8'($urandom_range(1, 16)), 1'b1, q);
        run_session(q);

        repeat (4) begin
            make_session(8'($urandom), 1'($urandom_range(0, 1)), q);
            run_session(q);
        end

`ifdef K2_LOADER_CHECKSUM_EN
        q = '{8'h01, 8'h12, 8'h03};
        run_session(q);
        trailer_flip = 8'h5A;
        run_session(q);
        trailer_flip = 8'h00;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
